// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with valid/ready handshakes on request and result.
// Single-cycle ops (0-11, divide by zero, or all of 12-15 when ENABLE_MULDIV=0)
// finish on the accept edge. MUL/MULH/DIV/MOD iterate one bit per edge using a
// shared hi/lo shift pair: shift-add for multiply, restoring for divide.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            request handshake; opcode/in1/in2/carry
//                                are latched on acceptance
//   out_valid/out_ready          result handshake; out/carry_out are
//                                registered and held while stalled
module alu_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  carry,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  carry_out
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [1:0]     mop_q;   // low opcode bits; BUSY implies opcode[3:2]==2'b11
  logic [W-1:0]   hi_q, lo_q, b_q;
  logic [SW-1:0]  cnt_q;

  logic           accept, is_multi;
  logic [SW-1:0]  sh;
  logic [W-1:0]   sc_out;
  logic           sc_co;
  logic [W:0]     wide_l, wide_r;
  logic signed [W:0] wide_a;
  logic [2*W-1:0] rot;

  logic [W:0]     mul_sum, div_sh, div_rem;
  logic           div_ge;
  logic [W-1:0]   hi_nx, lo_nx, it_out;
  logic           it_co;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign sh        = in2[SW-1:0];

  // Divide by zero never iterates; it resolves on the accept edge.
  assign is_multi = ENABLE_MULDIV && (opcode[3:2] == 2'b11) &&
                    !(opcode[1] && (in2 == '0));

  // Single-cycle result, computed straight from the request inputs.
  always_comb begin
    sc_out = '0;
    sc_co  = 1'b0;
    // Shift helpers: the extra bit catches the last bit shifted out.
    wide_l = {1'b0, in1} << sh;
    wide_r = {in1, 1'b0} >> sh;
    wide_a = $signed({in1, 1'b0}) >>> sh;
    rot    = {in1, in1} << sh;
    case (opcode)
      4'd0:  {sc_co, sc_out} = {1'b0, in1} + {1'b0, in2};
      4'd1:  {sc_co, sc_out} = {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, carry};
      4'd2:  {sc_co, sc_out} = {1'b0, in1} + {1'b0, ~in2} + {{W{1'b0}}, 1'b1};
      4'd3:  {sc_co, sc_out} = {1'b0, in1} + {1'b0, ~in2} + {{W{1'b0}}, carry};
      4'd4:  sc_out = in1 & in2;
      4'd5:  sc_out = in1 | in2;
      4'd6:  sc_out = in1 ^ in2;
      4'd7:  sc_out = ~in1;
      4'd8, 4'd9, 4'd10: begin
        if (sh == '0) begin
          sc_out = in1;
          sc_co  = carry;
        end else if (opcode == 4'd8) begin
          {sc_co, sc_out} = wide_l;
        end else if (opcode == 4'd9) begin
          {sc_out, sc_co} = wide_r;
        end else begin
          {sc_out, sc_co} = wide_a;
        end
      end
      4'd11: sc_out = rot[2*W-1:W];
      default: begin
        // 12-15 land here only as divide-by-zero or with muldiv disabled.
        if (ENABLE_MULDIV && opcode == 4'd14) begin
          sc_out = '1;
          sc_co  = 1'b1;
        end else if (ENABLE_MULDIV && opcode == 4'd15) begin
          sc_out = in1;
          sc_co  = 1'b1;
        end
      end
    endcase
  end

  // One iteration step. Multiply: hi accumulates, lo holds the multiplier and
  // fills with product bits from the top. Divide: hi is the partial remainder,
  // lo shifts the dividend out and the quotient in.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {hi_q, lo_q[W-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    div_rem = div_sh - {1'b0, b_q};
    if (!mop_q[1]) begin
      hi_nx = mul_sum[W:1];
      lo_nx = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      hi_nx = div_ge ? div_rem[W-1:0] : div_sh[W-1:0];
      lo_nx = {lo_q[W-2:0], div_ge};
    end
    it_co = 1'b0;
    case (mop_q)
      2'd0: begin it_out = lo_nx; it_co = |hi_nx; end
      2'd1: it_out = hi_nx;
      2'd2: it_out = lo_nx;
      default: it_out = hi_nx;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_multi ? BUSY : DONE;
      BUSY: if (cnt_q == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = accept ? (is_multi ? BUSY : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mop_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      out       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mop_q <= opcode[1:0];
        b_q   <= in2;
        hi_q  <= '0;
        lo_q  <= in1;
        cnt_q <= SW'(W-1);
        if (!is_multi) begin
          out       <= sc_out;
          carry_out <= sc_co;
        end
      end else if (state == BUSY) begin
        hi_q  <= hi_nx;
        lo_q  <= lo_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          out       <= it_out;
          carry_out <= it_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: single-cycle ops, iterative mul/div latency,
// divide by zero, output backpressure with back-to-back accept, mid-op reset,
// and a muldiv-disabled build.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_valid0 = 1'b0;
  logic         in_ready, in_ready0;
  logic [3:0]   opcode = '0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         carry = 1'b0;
  logic         out_valid, out_valid0;
  logic         out_ready = 1'b1;
  logic [W-1:0] out, out0;
  logic         carry_out, carry_out0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.DATA_WIDTH(W), .ENABLE_MULDIV(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in1(in1), .in2(in2), .carry(carry),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .carry_out(carry_out)
  );

  alu_seq #(.DATA_WIDTH(W), .ENABLE_MULDIV(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .opcode(opcode), .in1(in1), .in2(in2), .carry(carry),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .carry_out(carry_out0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request, accept it, scramble inputs, then count edges (accept
  // edge = 1) until out_valid is seen at a negedge.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c,
                       output int lat, output logic busy_rdy);
    @(negedge clk);
    opcode = op; in1 = a; in2 = b; carry = c; in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; opcode = 4'hF; in1 = '1; in2 = '0; carry = 1'b1;
    lat = 0;
    busy_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_rdy = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic c,
                     input logic [W-1:0] exp_out, input logic exp_co, input int exp_lat);
    int   lat;
    logic busy_rdy;
    issue(tag, op, a, b, c, lat, busy_rdy);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_co"}, 32'(carry_out), 32'(exp_co));
    if (exp_lat > 1) chk({tag, "_busy_in_ready"}, 32'(busy_rdy), 32'd0);
    @(negedge clk);
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   lat;
    logic busy_rdy;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_co", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle sweep
    run("add",  4'd0,  16'h3333, 16'h0005, 1'b0, 16'h3338, 1'b0, 1);
    run("sub",  4'd2,  16'h3333, 16'h0005, 1'b0, 16'h332E, 1'b1, 1);
    run("shl",  4'd8,  16'h3333, 16'h0005, 1'b0, 16'h6660, 1'b0, 1);
    run("adc",  4'd1,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1);
    run("shr0", 4'd9,  16'h00A5, 16'h0010, 1'b1, 16'h00A5, 1'b1, 1);
    run("shr3", 4'd9,  16'h00A5, 16'h0003, 1'b0, 16'h0014, 1'b1, 1);
    run("rol",  4'd11, 16'h8001, 16'h0004, 1'b1, 16'h0018, 1'b0, 1);
    run("sar",  4'd10, 16'h8000, 16'h0003, 1'b0, 16'hF000, 1'b0, 1);

    // Iterative ops: W+1 edges counting the accept edge
    run("mul",  4'd12, 16'h3333, 16'h0005, 1'b0, 16'hFFFF, 1'b0, 17);
    run("div",  4'd14, 16'h3333, 16'h0005, 1'b0, 16'h0A3D, 1'b0, 17);
    run("mod",  4'd15, 16'h3333, 16'h0005, 1'b0, 16'h0002, 1'b0, 17);
    run("mulh", 4'd13, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 17);

    // Divide by zero
    run("div0", 4'd14, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1);
    run("mod0", 4'd15, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b1, 1);

    // Output backpressure, then back-to-back accept from DONE
    out_ready = 1'b0;
    issue("mulhold", 4'd12, 16'h0100, 16'h0100, 1'b0, lat, busy_rdy);
    chk("mulhold_lat", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mulhold_stable", {14'd0, out_valid, carry_out, out}, {14'd0, 1'b1, 1'b1, 16'h0000});
      chk("mulhold_in_ready", 32'(in_ready), 32'd0);
    end
    opcode = 4'd0; in1 = 16'd1; in2 = 16'd1; carry = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_out", 32'(out), 32'h0002);
    @(negedge clk);
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a divide
    @(negedge clk);
    opcode = 4'd14; in1 = 16'hABCD; in2 = 16'h0007; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run("postrst_add", 4'd0, 16'd2, 16'd3, 1'b0, 16'h0005, 1'b0, 1);

    // Muldiv disabled build
    @(negedge clk);
    opcode = 4'd12; in1 = 16'd7; in2 = 16'd9; carry = 1'b0; in_valid0 = 1'b1;
    #1 chk("nomd_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    chk("nomd_valid", 32'(out_valid0), 32'd1);
    chk("nomd_out", 32'(out0), 32'd0);
    chk("nomd_co", 32'(carry_out0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
